// File: rtl/conv2d_pkg.sv
// Shared layout helpers and state type for the conv2d block family.
package conv2d_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Width of the flat channel-major frame vector.
  function automatic int unsigned FRAME_W(input int unsigned rows,
                                          input int unsigned cols,
                                          input int unsigned ch,
                                          input int unsigned ds);
    return rows * cols * ch * ds;
  endfunction

  // Bit offset of element (ci, r, c); element 0 sits in the LSBs.
  function automatic int unsigned ELEM_OFFSET(input int unsigned ci,
                                              input int unsigned r,
                                              input int unsigned c,
                                              input int unsigned rows,
                                              input int unsigned cols,
                                              input int unsigned ds);
    return ((ci * rows * cols) + (r * cols) + c) * ds;
  endfunction

  // Counter width for a bound, never less than one bit.
  function automatic int unsigned CNT_W(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv2d_pixel_counter.sv
// Nested channel/row/column position counter with enable, clear and wrap.
module conv2d_pixel_counter
  import conv2d_pkg::*;
#(
  parameter int unsigned CH   = 1,
  parameter int unsigned ROWS = 27,
  parameter int unsigned COLS = 27
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic                   i_clr,
  output logic [CNT_W(CH)-1:0]   o_ci,
  output logic [CNT_W(ROWS)-1:0] o_r,
  output logic [CNT_W(COLS)-1:0] o_c,
  output logic                   o_is_last
);

  localparam int unsigned CI_W = CNT_W(CH);
  localparam int unsigned R_W  = CNT_W(ROWS);
  localparam int unsigned C_W  = CNT_W(COLS);

  localparam logic [CI_W-1:0] CI_MAX = CI_W'(CH - 1);
  localparam logic [R_W-1:0]  R_MAX  = R_W'(ROWS - 1);
  localparam logic [C_W-1:0]  C_MAX  = C_W'(COLS - 1);

  logic [CI_W-1:0] r_ci;
  logic [R_W-1:0]  r_r;
  logic [C_W-1:0]  r_c;

  logic w_c_wrap;
  logic w_r_wrap;
  logic w_ci_wrap;

  assign w_c_wrap  = (r_c == C_MAX);
  assign w_r_wrap  = (r_r == R_MAX);
  assign w_ci_wrap = (r_ci == CI_MAX);

  // Advance column, carrying into row and then channel; wrap to zero after the last element
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_ci <= '0;
      r_r  <= '0;
      r_c  <= '0;
    end else if (i_en) begin
      if (w_c_wrap) begin
        r_c <= '0;
        if (w_r_wrap) begin
          r_r  <= '0;
          r_ci <= w_ci_wrap ? '0 : r_ci + 1'b1;
        end else begin
          r_r <= r_r + 1'b1;
        end
      end else begin
        r_c <= r_c + 1'b1;
      end
    end
  end

  assign o_ci      = r_ci;
  assign o_r       = r_r;
  assign o_c       = r_c;
  assign o_is_last = w_ci_wrap && w_r_wrap && w_c_wrap;

endmodule

// File: rtl/conv2d_frame_loader.sv
// Assembles a pixel stream into a flat channel-major frame for conv2d.
module conv2d_frame_loader
  import conv2d_pkg::*;
#(
  parameter int unsigned in_channels = 1,
  parameter int unsigned rows        = 27,
  parameter int unsigned cols        = 27,
  parameter int unsigned data_size   = 8
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 s_valid,
  output logic                                                 s_ready,
  input  logic signed [data_size-1:0]                          s_data,
  input  logic                                                 s_last,
  output logic [FRAME_W(rows, cols, in_channels, data_size)-1:0] frame_out,
  output logic                                                 frame_valid,
  input  logic                                                 frame_ready,
  output logic                                                 err_len
);

  localparam int unsigned FW    = FRAME_W(rows, cols, in_channels, data_size);
  localparam int unsigned OFF_W = (FW <= 1) ? 1 : $clog2(FW);
  localparam int unsigned CI_W  = CNT_W(in_channels);
  localparam int unsigned R_W   = CNT_W(rows);
  localparam int unsigned C_W   = CNT_W(cols);

  state_t          r_state;
  logic [FW-1:0]   r_frame;
  logic            r_err_len;

  logic [CI_W-1:0] w_ci;
  logic [R_W-1:0]  w_r;
  logic [C_W-1:0]  w_c;
  logic            w_is_last;
  logic            w_accept;
  logic            w_early;
  logic [OFF_W-1:0] w_off;

  assign w_accept = s_valid && (r_state == FILL);
  // An s_last before the final position aborts the frame; the counter restarts at zero.
  assign w_early  = w_accept && s_last && !w_is_last;
  assign w_off    = OFF_W'(ELEM_OFFSET(32'(w_ci), 32'(w_r), 32'(w_c),
                                       rows, cols, data_size));

  conv2d_pixel_counter #(
    .CH   (in_channels),
    .ROWS (rows),
    .COLS (cols)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_accept && !w_early),
    .i_clr     (w_early),
    .o_ci      (w_ci),
    .o_r       (w_r),
    .o_c       (w_c),
    .o_is_last (w_is_last)
  );

  // Frame state machine and one-cycle length-error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FILL;
      r_err_len <= 1'b0;
    end else begin
      r_err_len <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (w_is_last) begin
              r_state   <= FULL;
              r_err_len <= !s_last;
            end else if (s_last) begin
              r_err_len <= 1'b1;
            end
          end
        end
        FULL: begin
          if (frame_ready) r_state <= FILL;
        end
        default: r_state <= FILL;
      endcase
    end
  end

  // Write each accepted pixel into its slot; the frame is held untouched while FULL
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= '0;
    end else if (w_accept) begin
      r_frame[w_off +: data_size] <= s_data;
    end
  end

  assign s_ready     = (r_state == FILL);
  assign frame_valid = (r_state == FULL);
  assign frame_out   = r_frame;
  assign err_len     = r_err_len;

endmodule

// File: tb/tb_conv2d_frame_loader.sv
// Self-checking bench for conv2d_frame_loader (2 channels, 3x3, 8-bit pixels).
module tb_conv2d_frame_loader;

  localparam int unsigned CH   = 2;
  localparam int unsigned ROWS = 3;
  localparam int unsigned COLS = 3;
  localparam int unsigned DS   = 8;
  localparam int unsigned NPIX = CH * ROWS * COLS;
  localparam int unsigned FW   = NPIX * DS;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DS-1:0] s_data;
  logic          s_last;
  logic [FW-1:0] frame_out;
  logic          frame_valid;
  logic          frame_ready;
  logic          err_len;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [FW-1:0] sb[$];

  typedef struct {
    logic [7:0]  first;
    logic [7:0]  inc;
    bit          last_on_final;
    int unsigned hold;
    bit          rdy_fill;
  } vec_t;

  vec_t vecs[5];

  conv2d_frame_loader #(
    .in_channels (CH),
    .rows        (ROWS),
    .cols        (COLS),
    .data_size   (DS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkf(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream one full frame; value k is first + k*inc. Expected frame goes to the scoreboard.
  task automatic send_frame(input logic [7:0] first, input logic [7:0] inc,
                            input bit last_on_final, input bit rdy_fill);
    logic [FW-1:0] e;
    logic [7:0]    v;
    e = '0;
    v = first;
    frame_ready = rdy_fill;
    for (int k = 0; k < int'(NPIX); k++) begin
      chk1("s_ready_fill", s_ready, 1'b1);
      s_valid = 1'b1;
      s_data  = v;
      s_last  = (k == int'(NPIX) - 1) ? last_on_final : 1'b0;
      e = e | (FW'(v) << (k * 8));
      if (k == int'(NPIX) - 1) sb.push_back(e);
      tick();
      if (k < int'(NPIX) - 1) begin
        chk1("err_len_fill", err_len, 1'b0);
        chk1("frame_valid_fill", frame_valid, 1'b0);
      end
      v = v + inc;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk1("frame_valid_rise", frame_valid, 1'b1);
    chk1("err_len_final", err_len, !last_on_final);
    chk1("s_ready_full", s_ready, 1'b0);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      chkf("frame_out", frame_out, sb.pop_front());
    end
  endtask

  // Hold the frame for 'hold' cycles with junk upstream traffic, then release it.
  task automatic drain(input int unsigned hold);
    logic [FW-1:0] held;
    held = frame_out;
    frame_ready = 1'b0;
    for (int unsigned h = 0; h < hold; h++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
      tick();
      chk1("bp_s_ready", s_ready, 1'b0);
      chk1("bp_frame_valid", frame_valid, 1'b1);
      chk1("bp_err_len", err_len, 1'b0);
      chkf("bp_frame_stable", frame_out, held);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    frame_ready = 1'b1;
    tick();
    chk1("release_frame_valid", frame_valid, 1'b0);
    chk1("release_s_ready", s_ready, 1'b1);
    chk1("release_err_len", err_len, 1'b0);
    frame_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{first: 8'd1,   inc: 8'd1,   last_on_final: 1'b1, hold: 0, rdy_fill: 1'b1};
    vecs[1] = '{first: 8'd200, inc: 8'd3,   last_on_final: 1'b1, hold: 5, rdy_fill: 1'b0};
    vecs[2] = '{first: 8'h80,  inc: 8'h8F,  last_on_final: 1'b1, hold: 1, rdy_fill: 1'b0};
    vecs[3] = '{first: 8'h10,  inc: 8'd1,   last_on_final: 1'b0, hold: 0, rdy_fill: 1'b0};
    vecs[4] = '{first: 8'hFF,  inc: 8'hFF,  last_on_final: 1'b1, hold: 2, rdy_fill: 1'b1};

    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    frame_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk1("rst_s_ready", s_ready, 1'b1);
    chk1("rst_frame_valid", frame_valid, 1'b0);
    chk1("rst_err_len", err_len, 1'b0);
    chkf("rst_frame_out", frame_out, '0);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].first, vecs[i].inc, vecs[i].last_on_final, vecs[i].rdy_fill);
      if (i == 2) begin
        chk8("signed_first", frame_out[7:0], 8'h80);
        chk8("signed_last", frame_out[143:136], 8'hFF);
      end
      drain(vecs[i].hold);
    end

    // Early s_last on pixel 7: partial frame discarded, one-cycle error pulse.
    for (int k = 0; k < 7; k++) begin
      s_valid = 1'b1;
      s_data  = 8'(50 + k);
      s_last  = (k == 6);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk1("early_err_len", err_len, 1'b1);
    chk1("early_frame_valid", frame_valid, 1'b0);
    chk1("early_s_ready", s_ready, 1'b1);
    tick();
    chk1("early_err_len_drop", err_len, 1'b0);
    chk1("early_frame_valid_idle", frame_valid, 1'b0);
    send_frame(8'd101, 8'd1, 1'b1, 1'b0);
    chk8("after_early_byte0", frame_out[7:0], 8'd101);
    drain(0);

    // Reset after 10 pixels discards the partial frame.
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1;
      s_data  = 8'(70 + k);
      s_last  = 1'b0;
      tick();
    end
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("midrst_s_ready", s_ready, 1'b1);
    chk1("midrst_frame_valid", frame_valid, 1'b0);
    chk1("midrst_err_len", err_len, 1'b0);
    chkf("midrst_frame_out", frame_out, '0);
    send_frame(8'h33, 8'd5, 1'b1, 1'b0);
    drain(0);

    chk1("sb_drained", sb.size() == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
